instr_fetch_dispatch: RTL and testbench

INSTR_FETCH_DISPATCH -- requirements
Module: instr_fetch_dispatch

---
 rtl/instr_fetch_dispatch.sv | 128 ++++++++++++
 tb/tb_instr_fetch_dispatch.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_dispatch.sv
// Instruction sequencer: fetches a word, decodes its opcode and starts the matching
// execution FSM, with bounded waits on the memory and execution handshakes.
module instr_fetch_dispatch #(
  parameter int IW      = 16,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  input  logic          mem_ready,
  input  logic [IW-1:0] instr_in,
  input  logic          exec_done,
  output logic          pc_out_en,
  output logic          mem_read,
  output logic [IW-1:0] ir,
  output logic          start_reg_alu,
  output logic          start_imm_alu,
  output logic          start_mem,
  output logic          start_branch,
  output logic          pc_inc,
  output logic          halted,
  output logic          err,
  output logic [7:0]    instr_count
);

  localparam int WW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [3:0] {
    IDLE, FETCH, FETCH_WAIT, DECODE, DISPATCH, EXEC_WAIT, NOP, HALT, ERROR
  } state_t;

  state_t        state, next_state;
  logic [WW-1:0] wait_cnt;
  logic [3:0]    opcode;
  logic          timed_out;
  logic          in_wait;
  logic          retire;

  assign opcode    = ir[IW-1:IW-4];
  assign timed_out = (wait_cnt == WW'(TIMEOUT));
  assign in_wait   = (state == FETCH_WAIT) || (state == EXEC_WAIT);
  assign retire    = (state == NOP) || ((state == EXEC_WAIT) && exec_done);

  // Wait counter restarts whenever a wait state is entered or left.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= IDLE;
      ir          <= '0;
      instr_count <= '0;
      wait_cnt    <= '0;
    end else begin
      state <= next_state;
      if ((state == FETCH_WAIT) && mem_ready)
        ir <= instr_in;
      if (retire)
        instr_count <= instr_count + 8'd1;
      if (in_wait && (next_state == state))
        wait_cnt <= wait_cnt + WW'(1);
      else
        wait_cnt <= '0;
    end
  end

  always_comb begin
    next_state    = state;
    pc_out_en     = 1'b0;
    mem_read      = 1'b0;
    start_reg_alu = 1'b0;
    start_imm_alu = 1'b0;
    start_mem     = 1'b0;
    start_branch  = 1'b0;
    pc_inc        = 1'b0;
    halted        = 1'b0;
    err           = 1'b0;
    case (state)
      IDLE: begin
        if (run)
          next_state = FETCH;
      end
      FETCH: begin
        pc_out_en  = 1'b1;
        mem_read   = 1'b1;
        next_state = FETCH_WAIT;
      end
      // A handshake arriving on the timeout cycle still wins.
      FETCH_WAIT: begin
        pc_out_en = 1'b1;
        mem_read  = 1'b1;
        if (mem_ready)
          next_state = DECODE;
        else if (timed_out)
          next_state = ERROR;
      end
      DECODE: begin
        case (opcode)
          4'h0:                                            next_state = NOP;
          4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'h8: next_state = DISPATCH;
          4'hF:                                            next_state = HALT;
          default:                                         next_state = ERROR;
        endcase
      end
      DISPATCH: begin
        case (opcode)
          4'h1, 4'h2, 4'h3: start_reg_alu = 1'b1;
          4'h4, 4'h5, 4'h6: start_imm_alu = 1'b1;
          4'h7:             start_mem     = 1'b1;
          4'h8:             start_branch  = 1'b1;
          default:          ;
        endcase
        next_state = EXEC_WAIT;
      end
      EXEC_WAIT: begin
        if (exec_done)
          next_state = run ? FETCH : IDLE;
        else if (timed_out)
          next_state = ERROR;
      end
      NOP: begin
        pc_inc     = 1'b1;
        next_state = run ? FETCH : IDLE;
      end
      HALT:    halted = 1'b1;
      ERROR:   err    = 1'b1;
      default: next_state = IDLE;
    endcase
  end

endmodule

// File: tb/tb_instr_fetch_dispatch.sv
// Bench for instr_fetch_dispatch: an instruction-level model expands each instruction
// into a per-cycle table of inputs and expected outputs, which is then replayed.
module tb_instr_fetch_dispatch;

  localparam int TIMEOUT = 15;

  localparam logic [8:0] S_NONE  = 9'b000000000;
  localparam logic [8:0] S_FETCH = 9'b110000000;
  localparam logic [8:0] S_REG   = 9'b001000000;
  localparam logic [8:0] S_IMM   = 9'b000100000;
  localparam logic [8:0] S_MEM   = 9'b000010000;
  localparam logic [8:0] S_BR    = 9'b000001000;
  localparam logic [8:0] S_NOP   = 9'b000000100;
  localparam logic [8:0] S_HALT  = 9'b000000010;
  localparam logic [8:0] S_ERR   = 9'b000000001;

  localparam int K_IDLE = 0, K_FETCH = 1, K_HALT = 2, K_ERR = 3, K_MID = 4;
  localparam int C_NOP = 0, C_REG = 1, C_IMM = 2, C_MEM = 3, C_BR = 4, C_HALT = 5, C_ILL = 6;

  typedef struct {
    logic        rst_n;
    logic        run;
    logic        mem_ready;
    logic        exec_done;
    logic [15:0] instr;
    logic [8:0]  exp_strobe;
    logic [15:0] exp_ir;
    logic [7:0]  exp_cnt;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset, run, mem_ready, exec_done;
  logic [15:0] instr_in;
  logic        pc_out_en, mem_read, start_reg_alu, start_imm_alu, start_mem, start_branch;
  logic        pc_inc, halted, err;
  logic [15:0] ir;
  logic [7:0]  instr_count;

  vec_t        vq[$];
  logic [15:0] m_ir;
  logic [7:0]  m_cnt;
  int          m_next;
  int          n_checks = 0;
  int          n_errors = 0;

  always #5 clk = ~clk;

  instr_fetch_dispatch #(.IW(16), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .run(run), .mem_ready(mem_ready), .instr_in(instr_in),
    .exec_done(exec_done), .pc_out_en(pc_out_en), .mem_read(mem_read), .ir(ir),
    .start_reg_alu(start_reg_alu), .start_imm_alu(start_imm_alu), .start_mem(start_mem),
    .start_branch(start_branch), .pc_inc(pc_inc), .halted(halted), .err(err),
    .instr_count(instr_count)
  );

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic logic [15:0] rw();
    return 16'($urandom);
  endfunction

  function automatic int op_class(input logic [3:0] op);
    if (op == 4'd0)  return C_NOP;
    if (op <= 4'd3)  return C_REG;
    if (op <= 4'd6)  return C_IMM;
    if (op == 4'd7)  return C_MEM;
    if (op == 4'd8)  return C_BR;
    if (op == 4'd15) return C_HALT;
    return C_ILL;
  endfunction

  function automatic logic [8:0] start_strobe(input int cls);
    case (cls)
      C_REG:   return S_REG;
      C_IMM:   return S_IMM;
      C_MEM:   return S_MEM;
      default: return S_BR;
    endcase
  endfunction

  task automatic push(input logic [8:0] s, input logic rst_n, input logic r,
                      input logic mr, input logic ed, input logic [15:0] instr);
    vec_t v;
    v.rst_n      = rst_n;
    v.run        = r;
    v.mem_ready  = mr;
    v.exec_done  = ed;
    v.instr      = instr;
    v.exp_strobe = s;
    v.exp_ir     = m_ir;
    v.exp_cnt    = m_cnt;
    vq.push_back(v);
  endtask

  task automatic gen_reset(input int n);
    logic [8:0] s;
    case (m_next)
      K_FETCH: s = S_FETCH;
      K_HALT:  s = S_HALT;
      K_ERR:   s = S_ERR;
      default: s = S_NONE;
    endcase
    push(s, 1'b0, rb(), rb(), rb(), rw());
    m_ir  = '0;
    m_cnt = '0;
    for (int k = 1; k < n; k++) push(S_NONE, 1'b0, rb(), rb(), rb(), rw());
    m_next = K_IDLE;
  endtask

  task automatic gen_idle_start(input int n);
    if (m_next != K_IDLE) return;
    for (int k = 0; k < n; k++) push(S_NONE, 1'b1, 1'b0, rb(), rb(), rw());
    push(S_NONE, 1'b1, 1'b1, rb(), rb(), rw());
    m_next = K_FETCH;
  endtask

  task automatic gen_sticky(input int n);
    logic [8:0] s;
    s = (m_next == K_HALT) ? S_HALT : S_ERR;
    for (int k = 0; k < n; k++) push(s, 1'b1, rb(), rb(), rb(), rw());
  endtask

  // One instruction from FETCH to retirement; abort_exec >= 0 stops inside the execution wait.
  task automatic gen_instr(input logic [15:0] word, input int mem_lat, input int exec_lat,
                           input logic run_after, input int abort_exec);
    int cls;
    push(S_FETCH, 1'b1, rb(), rb(), rb(), rw());
    if (mem_lat > TIMEOUT) begin
      for (int k = 0; k <= TIMEOUT; k++) push(S_FETCH, 1'b1, rb(), 1'b0, rb(), rw());
      m_next = K_ERR;
      return;
    end
    for (int k = 0; k < mem_lat; k++) push(S_FETCH, 1'b1, rb(), 1'b0, rb(), rw());
    push(S_FETCH, 1'b1, rb(), 1'b1, rb(), word);
    m_ir = word;
    cls  = op_class(word[15:12]);
    push(S_NONE, 1'b1, rb(), rb(), rb(), rw());
    if (cls == C_NOP) begin
      push(S_NOP, 1'b1, run_after, rb(), rb(), rw());
      m_cnt  = m_cnt + 8'd1;
      m_next = run_after ? K_FETCH : K_IDLE;
      return;
    end
    if (cls == C_HALT) begin m_next = K_HALT; return; end
    if (cls == C_ILL)  begin m_next = K_ERR;  return; end
    push(start_strobe(cls), 1'b1, rb(), rb(), rb(), rw());
    if (abort_exec >= 0) begin
      for (int k = 0; k < abort_exec; k++) push(S_NONE, 1'b1, rb(), rb(), 1'b0, rw());
      m_next = K_MID;
      return;
    end
    if (exec_lat > TIMEOUT) begin
      for (int k = 0; k <= TIMEOUT; k++) push(S_NONE, 1'b1, rb(), rb(), 1'b0, rw());
      m_next = K_ERR;
      return;
    end
    for (int k = 0; k < exec_lat; k++) push(S_NONE, 1'b1, rb(), rb(), 1'b0, rw());
    push(S_NONE, 1'b1, run_after, rb(), 1'b1, rw());
    m_cnt  = m_cnt + 8'd1;
    m_next = run_after ? K_FETCH : K_IDLE;
  endtask

  task automatic recover();
    if (m_next == K_HALT || m_next == K_ERR) begin
      gen_sticky($urandom_range(1, 3));
      gen_reset($urandom_range(1, 2));
    end else if (m_next == K_MID) begin
      gen_reset($urandom_range(1, 2));
    end
    gen_idle_start($urandom_range(0, 2));
  endtask

  task automatic apply_stimulus(input int i);
    reset     = vq[i].rst_n;
    run       = vq[i].run;
    mem_ready = vq[i].mem_ready;
    exec_done = vq[i].exec_done;
    instr_in  = vq[i].instr;
  endtask

  task automatic check_output(input int i);
    logic [8:0] act;
    act = {pc_out_en, mem_read, start_reg_alu, start_imm_alu, start_mem, start_branch,
           pc_inc, halted, err};
    n_checks += 3;
    if (act !== vq[i].exp_strobe) begin
      n_errors++;
      $display("[TB] FAIL cycle %0d strobes: got %b expected %b", i, act, vq[i].exp_strobe);
    end
    if (ir !== vq[i].exp_ir) begin
      n_errors++;
      $display("[TB] FAIL cycle %0d ir: got %h expected %h", i, ir, vq[i].exp_ir);
    end
    if (instr_count !== vq[i].exp_cnt) begin
      n_errors++;
      $display("[TB] FAIL cycle %0d instr_count: got %0d expected %0d", i, instr_count, vq[i].exp_cnt);
    end
  endtask

  initial begin
    logic [3:0] op;
    int         abort;
    reset = 1'b0; run = 1'b0; mem_ready = 1'b0; exec_done = 1'b0; instr_in = '0;
    m_ir = '0; m_cnt = '0; m_next = K_IDLE;

    // Directed sequences.
    gen_reset(2);
    gen_idle_start(0);
    gen_instr(16'h4123, 1, 5, 1'b1, -1);
    gen_instr(16'h0000, 0, 0, 1'b0, -1);
    gen_idle_start(3);
    gen_instr(16'h1abc, 0, 1, 1'b1, -1);
    gen_instr(16'h7def, 2, 0, 1'b1, -1);
    gen_instr(16'h8001, 0, 3, 1'b1, -1);
    gen_instr(16'h2abc, TIMEOUT, TIMEOUT, 1'b1, -1);
    gen_instr(16'h5555, 0, 0, 1'b1, 3);
    gen_reset(2);
    gen_idle_start(0);
    gen_instr(16'h3333, 0, 2, 1'b0, -1);
    gen_idle_start(1);
    gen_instr(16'hF000, 0, 0, 1'b1, -1);
    gen_sticky(8);
    gen_reset(1);
    gen_idle_start(0);
    gen_instr(16'hA000, 0, 0, 1'b1, -1);
    gen_sticky(5);
    gen_reset(1);
    gen_idle_start(0);
    gen_instr(16'h6000, 0, TIMEOUT + 1, 1'b1, -1);
    gen_sticky(3);
    gen_reset(1);
    gen_idle_start(0);
    gen_instr(16'h1000, TIMEOUT + 1, 0, 1'b1, -1);
    gen_sticky(3);
    gen_reset(1);

    // Counter wrap: 255 retirements, then one more completing on the timeout cycle.
    gen_idle_start(0);
    for (int k = 0; k < 255; k++) gen_instr(16'h0000, 0, 0, 1'b1, -1);
    gen_instr(16'h4fff, 0, TIMEOUT, 1'b1, -1);
    gen_instr(16'h0000, 0, 0, 1'b0, -1);
    gen_reset(1);

    // Randomized program.
    gen_idle_start(0);
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 11))
        0:       op = 4'd0;
        9:       op = 4'd15;
        10, 11:  op = 4'($urandom_range(9, 14));
        default: op = 4'($urandom_range(1, 8));
      endcase
      abort = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, TIMEOUT)) : -1;
      gen_instr({op, 12'($urandom)},
                ($urandom_range(0, 15) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, 4)),
                ($urandom_range(0, 7) == 0) ? TIMEOUT + 1 : int'($urandom_range(0, TIMEOUT)),
                rb(), abort);
      recover();
    end
    gen_reset(1);

    repeat (2) @(posedge clk);
    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      check_output(i);
      apply_stimulus(i);
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
